// File: rtl/gsram_pkg.sv
// gsram_pkg: shared FSM state, mode encodings and default array size for gsram_ctrl
package gsram_pkg;
  typedef enum logic [2:0] {IDLE, FILL, WB, RD_ADDR, RD_DATA} state_e;
  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_WB      = 2'b01;
  localparam logic [1:0] MODE_RD      = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;
  localparam int ROWS_DEF = 10;
  localparam int COLS_DEF = 10;
endpackage

// File: rtl/gsram_ctrl_if.sv
// gsram_ctrl_if: command, requester handshakes and SRAM port of gsram_ctrl
interface gsram_ctrl_if #(parameter int AW = 4) ();
  logic          start;
  logic [1:0]    mode;
  logic          lut_valid;
  logic          lut_ready;
  logic          m2_valid;
  logic          m2_ready;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          gs_we;
  logic [AW-1:0] gs_row;
  logic [AW-1:0] gs_col;
  logic          gs_inmuxsel;
  logic          busy;
  logic          done;
  modport slave (
    input  start, mode, lut_valid, m2_valid, rd_ready,
    output lut_ready, m2_ready, rd_valid, rd_last, gs_we, gs_row, gs_col, gs_inmuxsel, busy, done
  );
  modport master (
    output start, mode, lut_valid, m2_valid, rd_ready,
    input  lut_ready, m2_ready, rd_valid, rd_last, gs_we, gs_row, gs_col, gs_inmuxsel, busy, done
  );
endinterface

// File: rtl/gsram_addr_ctr.sv
// gsram_addr_ctr: row-major row/col sweep counter; wraps to (0,0) after the last element
module gsram_addr_ctr #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);
  logic [AW-1:0] row_d, row_q, col_d, col_q;
  logic col_wrap;
  always_comb begin
    col_wrap = col_q == AW'(COLS - 1);
    last     = col_wrap && row_q == AW'(ROWS - 1);
    row_d    = (clr || (inc && last)) ? '0 : (inc && col_wrap) ? row_q + AW'(1) : row_q;
    col_d    = (clr || (inc && col_wrap)) ? '0 : inc ? col_q + AW'(1) : col_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign row = row_q;
  assign col = col_q;
endmodule

// File: rtl/gsram_ctrl.sv
// gsram_ctrl: GSRAM fill / M2 writeback / readout sweep controller.
// Define GSRAM_CTRL_STALLCNT_EN to add the saturating stall_cnt output.
module gsram_ctrl import gsram_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int AW   = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef GSRAM_CTRL_STALLCNT_EN
  output logic [15:0] stall_cnt,
`endif
  gsram_ctrl_if.slave bus
);
  state_e state_d, state_q;
  logic inc, clr, last;
  logic [AW-1:0] row, col;
  gsram_addr_ctr #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_ctr (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .row(row), .col(col), .last(last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d         = state_q;
    inc             = 1'b0;
    clr             = 1'b0;
    bus.lut_ready   = 1'b0;
    bus.m2_ready    = 1'b0;
    bus.rd_valid    = 1'b0;
    bus.rd_last     = 1'b0;
    bus.gs_we       = 1'b0;
    bus.gs_inmuxsel = 1'b0;
    bus.gs_row      = row;
    bus.gs_col      = col;
    bus.busy        = state_q != IDLE;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = bus.mode == MODE_FILL ? FILL : bus.mode == MODE_WB ? WB :
                  bus.mode == MODE_RD ? RD_ADDR : IDLE;
        clr     = state_d != IDLE;
      end
      FILL: begin
        bus.lut_ready   = 1'b1;
        bus.gs_inmuxsel = 1'b1;
        bus.gs_we       = bus.lut_valid;
        inc             = bus.lut_valid;
      end
      WB: begin
        bus.m2_ready = 1'b1;
        bus.gs_we    = bus.m2_valid;
        inc          = bus.m2_valid;
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        bus.rd_valid = 1'b1;
        bus.rd_last  = last;
        inc          = bus.rd_ready;
        state_d      = bus.rd_ready ? RD_ADDR : RD_DATA;
      end
      default: state_d = IDLE;
    endcase
    // the final handshake of any sweep ends it, whatever the mode
    bus.done = inc && last;
    if (bus.done) state_d = IDLE;
  end
`ifdef GSRAM_CTRL_STALLCNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic stall;
  always_comb begin
    stall = (state_q == FILL && !bus.lut_valid) || (state_q == WB && !bus.m2_valid) ||
            (state_q == RD_DATA && !bus.rd_ready);
    stall_cnt_d = clr ? '0 : (stall && !(&stall_cnt_q)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_gsram_ctrl.sv
// tb_gsram_ctrl: scoreboard bench for gsram_ctrl; write and readout beats are checked
// in order against entries queued when each sweep is launched.
module tb_gsram_ctrl;
  import gsram_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int done_at;
  logic [9:0] wr_q[$];
  logic [9:0] rd_q[$];
  logic [9:0] e;
  logic [15:0] outs;
`ifdef GSRAM_CTRL_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif
  gsram_ctrl_if #(.AW(4)) bus ();
  gsram_ctrl #(.ROWS(10), .COLS(10), .AW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef GSRAM_CTRL_STALLCNT_EN
    .stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign outs = {bus.gs_we, bus.gs_row, bus.gs_col, bus.gs_inmuxsel, bus.busy, bus.done,
                 bus.rd_valid, bus.rd_last, bus.lut_ready, bus.m2_ready};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [1:0] m);
    bus.start = 1'b1;
    bus.mode  = m;
    cyc();
    bus.start = 1'b0;
    bus.mode  = 2'b00;
  endtask

  // queue the first n elements of a row-major sweep: {row, col, flag, done}
  task automatic push_sweep(input bit wr, input logic mux, input int n);
    for (int k = 0; k < n; k++) begin
      logic lst;
      lst = (k == 99);
      if (wr) wr_q.push_back({4'(k / 10), 4'(k % 10), mux, lst});
      else    rd_q.push_back({4'(k / 10), 4'(k % 10), lst, lst});
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("rdy_excl", {31'd0, bus.lut_ready & bus.m2_ready}, 0);
    if (bus.gs_we) begin
      e = wr_q.size() != 0 ? wr_q.pop_front() : 10'h3FF;
      chk("wr_beat", {bus.gs_row, bus.gs_col, bus.gs_inmuxsel, bus.done}, e);
    end
    if (bus.rd_valid && bus.rd_ready) begin
      e = rd_q.size() != 0 ? rd_q.pop_front() : 10'h3FF;
      chk("rd_beat", {bus.gs_row, bus.gs_col, bus.rd_last, bus.done}, e);
    end
    if (bus.done && !bus.gs_we && !(bus.rd_valid && bus.rd_ready))
      chk("done_spurious", bus.done, 0);
  end

  initial begin
    bus.start = 0; bus.mode = 0; bus.lut_valid = 0; bus.m2_valid = 0; bus.rd_ready = 0;
    #12;
    chk("reset_outs", outs, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_outs", outs, 0);
    start_sweep(MODE_ILLEGAL);
    chk("illegal_busy", bus.busy, 0);
    chk("illegal_outs", outs, 0);
    // fill with a start pulse mid-sweep that must be ignored
    push_sweep(1, 1'b1, 100);
    start_sweep(MODE_FILL);
    for (int i = 0; i < 100; i++) begin
      bus.lut_valid = 1'b1;
      bus.start = (i == 50);
      bus.mode = MODE_RD;
      if (i == 51) chk("busy_start_ign", bus.lut_ready, 1);
      cyc();
    end
    bus.start = 0; bus.lut_valid = 0; bus.mode = 0;
    chk("fill_end_busy", bus.busy, 0);
    chk("fill_q_empty", wr_q.size(), 0);
    // writeback with valid gaps
    push_sweep(1, 1'b0, 100);
    start_sweep(MODE_WB);
    for (int i = 0; i < 200; i++) begin
      bus.m2_valid = (i % 2 == 0);
      #1;
      if (i < 6) chk("wb_we_gap", bus.gs_we, i % 2 == 0);
      cyc();
    end
    bus.m2_valid = 0;
    chk("wb_end_busy", bus.busy, 0);
    chk("wb_q_empty", wr_q.size(), 0);
    // readout with rd_ready tied high
    bus.rd_ready = 1'b1;
    push_sweep(0, 1'b0, 100);
    start_sweep(MODE_RD);
    done_at = 0;
    for (int k = 1; k <= 400 && done_at == 0; k++) begin
      if (k <= 4) chk("rd_valid_alt", bus.rd_valid, k % 2 == 0);
      if (bus.done) done_at = k;
      else cyc();
    end
    chk("rd_cycles", done_at, 200);
    cyc();
    chk("rd_end_busy", bus.busy, 0);
    chk("rd_q_empty", rd_q.size(), 0);
    // readout backpressure at (3,7)
    push_sweep(0, 1'b0, 100);
    start_sweep(MODE_RD);
    for (int k = 0; k < 400 && !(bus.rd_valid && bus.gs_row == 3 && bus.gs_col == 7); k++) cyc();
    bus.rd_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("bp_addr", {bus.gs_row, bus.gs_col}, 8'h37);
      chk("bp_valid", bus.rd_valid, 1);
      cyc();
    end
`ifdef GSRAM_CTRL_STALLCNT_EN
    chk("stall_cnt", stall_cnt, 5);
`endif
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 400 && bus.busy; k++) cyc();
    chk("bp_end_busy", bus.busy, 0);
    chk("bp_q_empty", rd_q.size(), 0);
    // asynchronous reset mid-writeback at (5,2)
    push_sweep(1, 1'b0, 52);
    start_sweep(MODE_WB);
    bus.m2_valid = 1'b1;
    for (int k = 0; k < 200 && !(bus.gs_row == 5 && bus.gs_col == 2); k++) cyc();
    bus.m2_valid = 1'b0;
    chk("rst_at", {bus.gs_row, bus.gs_col}, 8'h52);
    chk("rst_q_empty", wr_q.size(), 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs, 0);
    cyc();
    rst_n = 1'b1;
    bus.m2_valid = 1'b1;
    cyc();
    cyc();
    chk("post_rst_m2_ready", bus.m2_ready, 0);
    chk("post_rst_outs", outs, 0);
    bus.m2_valid = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gsram_ctrl.md
GSRAM_CTRL -- requirements
Module: gsram_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 10, giving the number of array rows swept.
REQ-002 The block SHALL have parameter COLS, default 10, giving the number of array columns swept.
REQ-003 The block SHALL have parameter AW, default 4, giving the row and column address width.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  begin sweep, sampled in IDLE only
- mode  in  2  00 LUT fill, 01 M2 writeback, 10 readout, 11 illegal
- lut_valid / lut_ready  in / out  1  LUT-source handshake
- m2_valid / m2_ready  in / out  1  M2-result handshake
- rd_valid / rd_ready  out / in  1  readout handshake; data is the SRAM rdata
- rd_last  out  1  with rd_valid on element (ROWS-1, COLS-1)
- gs_we  out  1  SRAM write enable
- gs_row / gs_col  out  AW  SRAM address
- gs_inmuxsel  out  1  1 = LUT data, 0 = M2 result
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at sweep end

Function
REQ-005 The FSM SHALL have exactly the states IDLE, FILL, WB, RD_ADDR and RD_DATA.
REQ-006 In IDLE, start=1 with mode 00/01/10 SHALL move to FILL/WB/RD_ADDR respectively, with the address at (0,0).
REQ-007 In IDLE, start=1 with mode 11 SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-008 In FILL, lut_ready SHALL be 1, gs_inmuxsel SHALL be 1, and gs_we SHALL equal lut_valid combinationally, so that a write commits on the same clock edge as the handshake.
REQ-009 In WB, m2_ready SHALL be 1, gs_inmuxsel SHALL be 0, and gs_we SHALL equal m2_valid combinationally.
REQ-010 The address SHALL advance only on a completed handshake, in row-major order: col+1; at col=COLS-1, col wraps to 0 and row increments.
REQ-011 A handshake at (ROWS-1, COLS-1) SHALL pulse done in the same cycle, return to IDLE on the next edge, and reset the address to (0,0).
REQ-012 RD_ADDR SHALL present the address for one cycle with rd_valid=0 and then move to RD_DATA, covering the SRAM's one-cycle read latency.
REQ-013 In RD_DATA, rd_valid SHALL be 1 and the address SHALL be held, so that rdata stays stable.
REQ-014 In RD_DATA, rd_ready=1 SHALL complete the transfer: the address advances and the FSM returns to RD_ADDR, or to IDLE with done after the last element.
REQ-015 In RD_ADDR and RD_DATA, gs_we SHALL be 0.
REQ-016 The ready signal of every idle requester SHALL be 0, and lut_ready and m2_ready SHALL never be 1 in the same cycle.
REQ-017 start asserted while busy SHALL be ignored, and mode SHALL be sampled only on acceptance of start.
REQ-018 In IDLE, gs_we, gs_row, gs_col, gs_inmuxsel, busy, done, rd_valid, rd_last, lut_ready and m2_ready SHALL all be 0.
REQ-019 A readout element SHALL take a minimum of 2 cycles, and a full ROWS*COLS readout SHALL take 200 cycles with rd_ready tied to 1.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, address (0,0) and all outputs to their REQ-018 values, including mid-sweep.
REQ-021 After reset release, a new start SHALL be required, and an interrupted sweep SHALL NOT resume.

Configuration
REQ-022 With GSRAM_CTRL_STALLCNT_EN defined, the block SHALL add output stall_cnt [15:0]:
- it counts cycles in FILL with lut_valid=0, in WB with m2_valid=0, and in RD_DATA with rd_ready=0
- it saturates at 16'hFFFF
- it clears on rst_n and on start acceptance
REQ-023 Without GSRAM_CTRL_STALLCNT_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Package gsram_pkg SHALL hold:
- the FSM state enum
- the mode encodings MODE_FILL, MODE_WB, MODE_RD and MODE_ILLEGAL
- the default ROWS and COLS constants
REQ-025 Row/column wrap counting SHALL be in sub-module gsram_addr_ctr, with inputs inc and clr and outputs row, col and last.

Verification
REQ-026 Fill: start, mode=00, lut_valid=1 for 100 cycles -> gs_we=1 and gs_inmuxsel=1 on each, addresses (0,0)..(9,9) in order, done in cycle 100, busy=0 after.
REQ-027 WB with gaps: m2_valid toggled 1,0,1,0 -> gs_we only in valid cycles, address advances only on valid, col 9 -> 0 with row+1 at the wrap.
REQ-028 Readout with rd_ready=1: rd_valid every second cycle, 100 beats, rd_last only on beat 100 with row=9 and col=9, done on that cycle.
REQ-029 Readout backpressure: rd_ready=0 for 5 cycles at (3,7) -> address held at (3,7) and rd_valid held at 1; stall_cnt=5 when the macro is enabled.
REQ-030 Illegal and busy starts: start with mode=11 -> stays IDLE; start pulsed mid-FILL -> no effect on address or state.
REQ-031 Reset mid-sweep: rst_n low at (5,2) in WB -> outputs zero asynchronously, and after release m2_ready=0 until a new start.
